// File: rtl/axi3_sram_rd_slave.sv
// rtl/axi3_sram_rd_slave.sv - AXI3 read-only slave serving bursts from a single-port SRAM
// One SRAM read per beat; every accepted burst returns len+1 beats even when they carry errors.
module axi3_sram_rd_slave #(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_AW     = 10
) (
  input  logic                  aclk,
  input  logic                  areset_n,
  input  logic [ID_WIDTH-1:0]   arid,
  input  logic [ADDR_WIDTH-1:0] araddr,
  input  logic [3:0]            arlen,
  input  logic [2:0]            arsize,
  input  logic [1:0]            arburst,
  input  logic [1:0]            arlock,
  input  logic [3:0]            arcache,
  input  logic [2:0]            arprot,
  input  logic                  arvalid,
  output logic                  arready,
  output logic [ID_WIDTH-1:0]   rid,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [1:0]            rresp,
  output logic                  rlast,
  output logic                  rvalid,
  input  logic                  rready,
  output logic                  mem_re,
  output logic [MEM_AW-1:0]     mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int B = $clog2(DATA_WIDTH / 8);
  localparam logic [2:0] MAX_SIZE = 3'(B);
  localparam logic [ADDR_WIDTH-1:0] ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  typedef enum logic [1:0] {IDLE, RD, RESP} state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [3:0]              len_q;
  logic [2:0]              size_q;
  logic [1:0]              burst_q;
  logic [3:0]              beat_q;
  logic                    slv_q;
  logic                    first_q;
  logic [DATA_WIDTH-1:0]   rdata_hold;

  logic [ADDR_WIDTH-1:0]   addr_nxt;
  logic [ADDR_WIDTH-1:0]   iss_addr;
  logic                    iss_slv;
  logic [1:0]              iss_resp;

  logic unused_sideband;
  assign unused_sideband = ^{arlock, arcache, arprot};

  // Burst-wide errors are decided once at AR time and then apply to every beat.
  function automatic logic burst_err(input logic [ADDR_WIDTH-1:0] a, input logic [3:0] len,
                                     input logic [2:0] size, input logic [1:0] burst);
    logic [ADDR_WIDTH-1:0] s_mask;
    logic                  wrap_len_ok;
    s_mask      = (ONE << size) - ONE;
    wrap_len_ok = (len == 4'd1) || (len == 4'd3) || (len == 4'd7) || (len == 4'd15);
    return (size > MAX_SIZE) || (burst == 2'b11) ||
           ((burst == 2'b10) && (!wrap_len_ok || ((a & s_mask) != '0)));
  endfunction

  function automatic logic dec_err(input logic [ADDR_WIDTH-1:0] a);
    return a[ADDR_WIDTH-1:MEM_AW+B] != '0;
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a,
                                                      input logic [3:0] len,
                                                      input logic [2:0] size,
                                                      input logic [1:0] burst);
    logic [ADDR_WIDTH-1:0] s;
    logic [ADDR_WIDTH-1:0] w;
    s = ONE << size;
    w = {{(ADDR_WIDTH-5){1'b0}}, ({1'b0, len} + 5'd1)} << size;
    case (burst)
      2'b01:   return (a & ~(s - ONE)) + s;
      2'b10:   return (a & ~(w - ONE)) | ((a + s) & (w - ONE));
      default: return a;
    endcase
  endfunction

  // The beat about to be issued comes from the AR channel in IDLE, else from the burst state.
  always_comb begin
    addr_nxt = next_addr(addr_q, len_q, size_q, burst_q);
    if (state == IDLE) begin
      iss_addr = araddr;
      iss_slv  = burst_err(araddr, arlen, arsize, arburst);
    end else begin
      iss_addr = addr_nxt;
      iss_slv  = slv_q;
    end
    iss_resp = iss_slv ? SLVERR : (dec_err(iss_addr) ? DECERR : OKAY);
  end

  // SRAM data is live only in the first RESP cycle; after that the hold copy keeps rdata stable.
  assign rdata = first_q ? ((rresp == OKAY) ? mem_rdata : '0) : rdata_hold;

  always_ff @(posedge aclk) begin
    if (!areset_n) begin
      state      <= IDLE;
      arready    <= 1'b0;
      rvalid     <= 1'b0;
      rlast      <= 1'b0;
      rid        <= '0;
      rresp      <= OKAY;
      mem_re     <= 1'b0;
      mem_addr   <= '0;
      rdata_hold <= '0;
      first_q    <= 1'b0;
      addr_q     <= '0;
      len_q      <= '0;
      size_q     <= '0;
      burst_q    <= '0;
      beat_q     <= '0;
      slv_q      <= 1'b0;
    end else begin
      first_q <= 1'b0;
      if (first_q) rdata_hold <= rdata;
      case (state)
        IDLE: begin
          if (arvalid && arready) begin
            rid      <= arid;
            addr_q   <= araddr;
            len_q    <= arlen;
            size_q   <= arsize;
            burst_q  <= arburst;
            beat_q   <= '0;
            slv_q    <= iss_slv;
            arready  <= 1'b0;
            mem_re   <= (iss_resp == OKAY);
            mem_addr <= iss_addr[MEM_AW+B-1:B];
            rresp    <= iss_resp;
            state    <= RD;
          end else begin
            arready <= 1'b1;
          end
        end
        RD: begin
          mem_re  <= 1'b0;
          rvalid  <= 1'b1;
          rlast   <= (beat_q == len_q);
          first_q <= 1'b1;
          state   <= RESP;
        end
        RESP: begin
          if (rready) begin
            rvalid <= 1'b0;
            rlast  <= 1'b0;
            if (rlast) begin
              arready <= 1'b1;
              state   <= IDLE;
            end else begin
              beat_q   <= beat_q + 4'd1;
              addr_q   <= addr_nxt;
              mem_re   <= (iss_resp == OKAY);
              mem_addr <= iss_addr[MEM_AW+B-1:B];
              rresp    <= iss_resp;
              state    <= RD;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi3_sram_rd_slave.sv
// tb/tb_axi3_sram_rd_slave.sv - scoreboard bench for axi3_sram_rd_slave
module tb_axi3_sram_rd_slave;

  logic        aclk = 1'b0;
  logic        areset_n;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [3:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [1:0]  arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;
  logic        mem_re;
  logic [9:0]  mem_addr;
  logic [31:0] mem_rdata = 32'h0;

  always #5 aclk = ~aclk;

  axi3_sram_rd_slave #(.ID_WIDTH(4), .ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_AW(10)) dut (
    .aclk(aclk), .areset_n(areset_n),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .mem_re(mem_re), .mem_addr(mem_addr), .mem_rdata(mem_rdata)
  );

  logic [31:0] mem [0:1023];
  always @(posedge aclk) if (mem_re) mem_rdata <= mem[mem_addr];

  typedef struct {
    logic [3:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } beat_t;

  beat_t      exp_q[$];
  logic [9:0] maddr_q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_hs = 0;
  int last_rlast = 0;
  int r_hs = 0;
  logic rvalid_prev = 1'b0;
  beat_t mon_e;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  always @(posedge aclk) cyc <= cyc + 1;

  always @(negedge aclk) begin
    if (areset_n) begin
      if (rvalid && !rvalid_prev) check_eq("latency", 64'(cyc - last_hs), 64'd2);
      if (mem_re) begin
        if (maddr_q.size() == 0) check_eq("mem_re_unexp", mem_re, 0);
        else check_eq("mem_addr", mem_addr, maddr_q.pop_front());
      end
      if (rvalid && rready) begin
        if (exp_q.size() == 0) check_eq("r_unexp", rvalid, 0);
        else begin
          mon_e = exp_q.pop_front();
          check_eq("rid", rid, mon_e.id);
          check_eq("rdata", rdata, mon_e.data);
          check_eq("rresp", rresp, mon_e.resp);
          check_eq("rlast", rlast, mon_e.last);
        end
        last_hs = cyc;
        r_hs++;
        if (rlast) last_rlast = cyc;
      end
      if (arvalid && arready) last_hs = cyc;
      if (arready) check_eq("arready_busy", {rvalid, mem_re}, 0);
    end
    rvalid_prev = rvalid;
  end

  // Reference model: expected beats and SRAM word addresses for one burst.
  task automatic push_burst(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                            input logic [2:0] size, input logic [1:0] burst);
    logic [31:0] a, s, w, base;
    logic        slv;
    beat_t       e;
    s = 32'd1 << size;
    w = ({28'd0, len} + 32'd1) * s;
    slv = (size > 3'd2) || (burst == 2'b11) ||
          (burst == 2'b10 && !(len == 4'd1 || len == 4'd3 || len == 4'd7 || len == 4'd15)) ||
          (burst == 2'b10 && (addr % s) != 0);
    a = addr;
    for (int i = 0; i <= int'(len); i++) begin
      e.id = id;
      if (slv) e.resp = 2'b10;
      else if ((a >> 2) >= 32'd1024) e.resp = 2'b11;
      else e.resp = 2'b00;
      e.data = (e.resp == 2'b00) ? mem[a[11:2]] : 32'h0;
      e.last = (i == int'(len));
      if (e.resp == 2'b00) maddr_q.push_back(a[11:2]);
      exp_q.push_back(e);
      if (burst == 2'b01) a = (a / s) * s + s;
      else if (burst == 2'b10) begin
        base = (a / w) * w;
        a = base + ((a - base + s) % w);
      end
    end
  endtask

  task automatic do_ar(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                       input logic [2:0] size, input logic [1:0] burst, input bit keep,
                       output int acc_cyc);
    @(posedge aclk); #1;
    push_burst(id, addr, len, size, burst);
    arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
    acc_cyc = -1;
    for (int i = 0; i < 300; i++) begin
      @(negedge aclk);
      if (arready) begin
        acc_cyc = cyc;
        break;
      end
    end
    if (acc_cyc < 0) check_eq("ar_timeout", arready, 1);
    @(posedge aclk); #1;
    if (!keep) arvalid = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 500; i++) begin
      @(negedge aclk);
      if (exp_q.size() == 0) break;
    end
    check_eq("drain", exp_q.size(), 0);
  endtask

  task automatic wait_rvalid();
    for (int i = 0; i < 50; i++) begin
      @(negedge aclk);
      if (rvalid) break;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

  int acc, acc2, base_hs;

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = (i * 32'h9E3779B1) ^ 32'h00C0FFEE;
    mem[4] = 32'hA5A5A5A5;
    areset_n = 1'b0; rready = 1'b1; arvalid = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0;
    arlock = '0; arcache = '0; arprot = '0;
    repeat (3) @(posedge aclk);
    #1;
    check_eq("rst_arready", arready, 0);
    check_eq("rst_rvalid", rvalid, 0);
    check_eq("rst_rlast", rlast, 0);
    check_eq("rst_rid", rid, 0);
    check_eq("rst_rdata", rdata, 0);
    check_eq("rst_rresp", rresp, 0);
    check_eq("rst_mem_re", mem_re, 0);
    check_eq("rst_mem_addr", mem_addr, 0);
    areset_n = 1'b1;
    @(posedge aclk); #1;
    check_eq("arready_post_rst", arready, 1);

    do_ar(4'd3, 32'h10, 4'd0, 3'd2, 2'b01, 0, acc);
    wait_done();

    // INCR burst with a 5-cycle stall on beat 1
    rready = 1'b0;
    do_ar(4'd1, 32'h0, 4'd3, 3'd2, 2'b01, 0, acc);
    wait_rvalid();
    @(posedge aclk); #1; rready = 1'b1;
    @(posedge aclk); #1; rready = 1'b0;
    wait_rvalid();
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge aclk);
      check_eq("hold_rvalid", rvalid, 1);
      if (exp_q.size() > 0) begin
        check_eq("hold_rdata", rdata, exp_q[0].data);
        check_eq("hold_rlast", rlast, exp_q[0].last);
        check_eq("hold_rid", rid, exp_q[0].id);
      end
    end
    @(posedge aclk); #1; rready = 1'b1;
    wait_done();

    do_ar(4'd2, 32'h18, 4'd3, 3'd2, 2'b10, 0, acc);   wait_done();
    do_ar(4'd4, 32'h18, 4'd2, 3'd2, 2'b10, 0, acc);   wait_done();
    do_ar(4'd8, 32'h1A, 4'd3, 3'd2, 2'b10, 0, acc);   wait_done();
    do_ar(4'd9, 32'h0, 4'd1, 3'd3, 2'b01, 0, acc);    wait_done();
    do_ar(4'd10, 32'h20, 4'd1, 3'd2, 2'b11, 0, acc);  wait_done();
    do_ar(4'd11, 32'h1000, 4'd1, 3'd2, 2'b01, 0, acc); wait_done();
    do_ar(4'd12, 32'h8, 4'd2, 3'd2, 2'b00, 0, acc);   wait_done();
    do_ar(4'd13, 32'h13, 4'd2, 3'd2, 2'b01, 0, acc);  wait_done();
    do_ar(4'd14, 32'h21, 4'd3, 3'd0, 2'b01, 0, acc);  wait_done();
    do_ar(4'd15, 32'hFFFFFFFC, 4'd1, 3'd2, 2'b01, 0, acc); wait_done();
    do_ar(4'd6, 32'h3C, 4'd7, 3'd2, 2'b10, 0, acc);   wait_done();

    // Back-to-back with arvalid held high
    do_ar(4'd5, 32'h40, 4'd1, 3'd2, 2'b01, 1, acc);
    do_ar(4'd6, 32'h80, 4'd0, 3'd2, 2'b01, 0, acc2);
    check_eq("b2b_accept", 64'(acc2), 64'(last_rlast + 1));
    wait_done();

    // Reset while beat 2 of a len=7 burst is presented
    base_hs = r_hs;
    do_ar(4'd7, 32'h100, 4'd7, 3'd2, 2'b01, 0, acc);
    for (int i = 0; i < 100; i++) begin
      if (r_hs >= base_hs + 2) break;
      @(negedge aclk);
    end
    @(posedge aclk); #1; rready = 1'b0;
    wait_rvalid();
    check_eq("beat2_present", rvalid, 1);
    @(posedge aclk); #1; areset_n = 1'b0;
    @(posedge aclk); #1;
    check_eq("rst_mid_rvalid", rvalid, 0);
    check_eq("rst_mid_arready", arready, 0);
    exp_q.delete();
    maddr_q.delete();
    @(posedge aclk); #1;
    areset_n = 1'b1; rready = 1'b1;
    @(posedge aclk); #1;
    check_eq("arready_after_mid_rst", arready, 1);
    repeat (3) begin
      @(negedge aclk);
      check_eq("no_beat_after_rst", rvalid, 0);
    end
    do_ar(4'd9, 32'h10, 4'd0, 3'd2, 2'b01, 0, acc);
    wait_done();

    repeat (3) @(negedge aclk);
    check_eq("mem_q_drain", maddr_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi3_sram_rd_slave.md
AXI3_SRAM_RD_SLAVE -- requirements
Module: axi3_sram_rd_slave

Interface
REQ-001 Parameter ID_WIDTH, default 4: width of arid/rid.
REQ-002 Parameter ADDR_WIDTH, default 32: byte address width of araddr.
REQ-003 Parameter DATA_WIDTH, default 32: rdata/mem_rdata width; power of two, 8..1024.
REQ-004 Parameter MEM_AW, default 10: SRAM word-address width; depth = 2**MEM_AW words of DATA_WIDTH.
REQ-005 Clock and reset are aclk and areset_n. Reset is synchronous and active-low: all state updates on the rising edge of aclk, and areset_n==0 sampled at that edge resets the block.
REQ-006 aclk  in  1  clock.
REQ-007 areset_n  in  1  synchronous active-low reset.
REQ-008 arid/araddr/arlen[3:0]/arsize[2:0]/arburst[1:0]/arvalid  in  per params  AXI3 AR channel, slave side; arlock/arcache/arprot are accepted and ignored.
REQ-009 arready  out  1  AR accept.
REQ-010 rid/rdata/rresp[1:0]/rlast/rvalid  out  per params  AXI3 R channel, slave side.
REQ-011 rready  in  1  R accept.
REQ-012 mem_re  out  1  SRAM read enable.
REQ-013 mem_addr  out  MEM_AW  SRAM word address.
REQ-014 mem_rdata  in  DATA_WIDTH  SRAM data: valid the cycle after mem_re; held stable until the next mem_re.

Function
REQ-015 The block SHALL implement the FSM IDLE -> RD -> RESP; RESP -> RD when not the last beat; RESP -> IDLE on the last beat.
REQ-016 arready SHALL be 1 only in IDLE and not in reset; an AR handshake (arvalid&&arready) SHALL latch id, addr, len, size, burst, and clear the beat counter.
REQ-017 RD SHALL last exactly 1 cycle: mem_re=1 and mem_addr=addr[MEM_AW+B-1:B], where B=log2(DATA_WIDTH/8); mem_re=0 in RD for error beats.
REQ-018 RESP SHALL drive rvalid=1 with rid=latched id, rdata=mem_rdata (0 for error beats), and rlast=1 iff beat count==len.
REQ-019 All R outputs SHALL remain stable while rvalid&&!rready; the FSM SHALL leave RESP only on rready.
REQ-020 Latency: AR handshake at cycle T gives first rvalid at T+2; each following beat asserts rvalid 2 cycles after the previous R handshake.
REQ-021 Address update after each beat, with S=1<<size:
  - FIXED (00): addr unchanged.
  - INCR (01): addr = (addr & ~(S-1)) + S; an unaligned start is served on beat 0 only; wraps modulo 2**ADDR_WIDTH.
  - WRAP (10): with W=(len+1)*S, addr = (addr & ~(W-1)) | ((addr+S) & (W-1)).
REQ-022 SLVERR (rresp=2'b10) SHALL be returned for every beat of a burst with any of: S > DATA_WIDTH/8; burst==2'b11; WRAP with len not in {1,3,7,15}; WRAP with an unaligned start.
REQ-023 DECERR (rresp=2'b11) SHALL be returned per beat when addr>>B >= 2**MEM_AW; SLVERR takes priority over DECERR.
REQ-024 Otherwise rresp SHALL be OKAY (2'b00).
REQ-025 Every accepted burst SHALL produce exactly len+1 R beats regardless of errors; no AR is accepted until the last beat completes.
REQ-026 Narrow transfers SHALL return the full memory word; byte-lane placement is the master's concern.

Reset
REQ-027 While areset_n==0 at a clock edge, next state SHALL be:
  - FSM=IDLE; arready=0 during reset and 1 in the first cycle after release.
  - rvalid=0, rlast=0, rid=0, rdata hold register=0, rresp=0, mem_re=0, mem_addr=0.
REQ-028 Reset mid-burst SHALL abandon the burst with no further beats; the first AR after release SHALL be served normally.

Verification
REQ-029 Single beat: araddr=0x10, len=0, size=2, INCR, arid=3, mem word 4=0xA5A5A5A5, rready=1 -> mem_re at T+1 with mem_addr=4; rvalid/rlast at T+2; rdata=0xA5A5A5A5, rid=3, rresp=0.
REQ-030 INCR burst: araddr=0x0, len=3, size=2 -> mem_addr 0,1,2,3; rlast on the 4th beat only. With rready=0 for 5 cycles on beat 1, R outputs are held unchanged.
REQ-031 WRAP burst: araddr=0x18, len=3, size=2 -> word addresses 6,7,4,5; len=2 WRAP -> 3 beats, all SLVERR, mem_re never asserted.
REQ-032 Error cases:
  - size=3 at DATA_WIDTH=32 -> SLVERR.
  - araddr=0x1000 with MEM_AW=10 -> DECERR on every beat, rdata=0.
  - FIXED len=2 at 0x8 -> mem_addr=2 three times.
REQ-033 Reset during beat 2 of a len=7 burst -> rvalid=0 the next cycle; arready=1 the cycle after release; a new len=0 burst completes correctly.
REQ-034 Back-to-back: arvalid held high across two bursts -> second AR accepted in the cycle after the first burst's last R handshake, never earlier.
